fifo_sync_ctrl: RTL



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/pkg_dual_ram.sv | 24 ++
 rtl/fifo_sync_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller family.
package fifo_pkg;

   // Default storage depth (log2) and the pointer width it implies.
   localparam int DEPTH_LOG_DEF = 8;
   localparam int PTR_W         = DEPTH_LOG_DEF + 1;

   // Pointer width for an arbitrary depth: one extra wrap bit above the address.
   function automatic int ptr_width(input int depth_log);
      return depth_log + 1;
   endfunction

   // Occupancy from write/read pointers, modulo 2^pw (pointers wrap naturally).
   function automatic logic [31:0] ptr_count(input logic [31:0] wr,
                                             input logic [31:0] rd,
                                             input int unsigned pw);
      return (wr - rd) & ((32'd1 << pw) - 32'd1);
   endfunction

endpackage

// File: rtl/pkg_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// on contents or read data.
module pkg_dual_ram #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [DEPTH_LOG-1:0] i_waddr,
   input  logic [WIDTH-1:0]     i_wdata,
   input  logic                 i_re,
   input  logic [DEPTH_LOG-1:0] i_raddr,
   output logic [WIDTH-1:0]     o_rdata
);

   logic [WIDTH-1:0] r_mem [2**DEPTH_LOG];

   // Write on strobe; read data is registered and held between reads.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, flags and sticky error bits around
// a dual-port RAM used as circular storage.
module fifo_sync_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH_LOG   = 8,
   parameter int AFULL_LEVEL = 2**DEPTH_LOG - 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic                 pop_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic [DEPTH_LOG:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int P_W = ptr_width(DEPTH_LOG);

   logic [P_W-1:0] r_wr_ptr;
   logic [P_W-1:0] r_rd_ptr;
   logic           r_pop_valid;
   logic           r_ovf;
   logic           r_unf;

   logic           w_full;
   logic           w_empty;
   logic [P_W-1:0] w_count;
   logic           w_push_ok;
   logic           w_pop_ok;

   // Flags decode straight from the registered pointers, so they follow reset
   // immediately and update the cycle after an accepting edge.
   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]) &&
                  (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]);
      w_count   = P_W'(ptr_count(32'(r_wr_ptr), 32'(r_rd_ptr), P_W));
      // A flush wins over both requests and suppresses the RAM write.
      w_push_ok = push && !w_full && !clr;
      w_pop_ok  = pop && !w_empty && !clr;
   end

   // Pointer advance, pop_valid delay and sticky error capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else if (clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + P_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + P_W'(1);
         r_pop_valid <= w_pop_ok;
         if (push && w_full) r_ovf <= 1'b1;
         if (pop && w_empty) r_unf <= 1'b1;
      end
   end

   // Registered read port supplies the single cycle of pop latency.
   pkg_dual_ram #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr[DEPTH_LOG-1:0]),
      .i_wdata (push_data),
      .i_re    (w_pop_ok),
      .i_raddr (r_rd_ptr[DEPTH_LOG-1:0]),
      .o_rdata (pop_data)
   );

   assign pop_valid   = r_pop_valid;
   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = w_count;
   assign almost_full = (w_count >= P_W'(AFULL_LEVEL));
   assign overflow    = r_ovf;
   assign underflow   = r_unf;

endmodule
